// File: rtl/echo_pkg.sv
// echo_pkg: types and constants shared by the echo-path blocks (serializer state, default
// message/beat widths, beat-count helper).
package echo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    localparam int ECHO_MSG_WIDTH  = 704;
    localparam int ECHO_BEAT_WIDTH = 32;

    // Returns 0 when in_w is not a positive whole multiple of out_w, so callers can refuse it.
    function automatic int serializer_beats(input int in_w, input int out_w);
        if (out_w <= 0 || in_w < out_w || (in_w % out_w) != 0) begin
            return 0;
        end
        return in_w / out_w;
    endfunction

endpackage

// File: rtl/pipe_serializer_if.sv
// pipe_serializer_if: wide-word dequeue side and narrow-beat enqueue side of pipe_serializer.
// out_last and words_sent exist only when SERIALIZER_LAST_EN is defined.
interface pipe_serializer_if #(
    parameter int IN_WIDTH  = echo_pkg::ECHO_MSG_WIDTH,
    parameter int OUT_WIDTH = echo_pkg::ECHO_BEAT_WIDTH
);
    // Handshake: a dequeue happens on every cycle with in_deq_ena=1, which is only raised while
    // in_first_rdy & in_deq_rdy are both high; a beat transfers on every cycle with
    // out_enq_ena=1, which is only raised while out_enq_rdy=1. There is no separate valid/accept
    // pairing beyond these strobes.
    logic [IN_WIDTH-1:0]  in_first;
    logic                 in_first_rdy;
    logic                 in_deq_rdy;
    logic                 in_deq_ena;
    logic [OUT_WIDTH-1:0] out_enq_v;
    logic                 out_enq_rdy;
    logic                 out_enq_ena;
    logic                 busy;
    echo_pkg::ser_state_e dbg_state;
`ifdef SERIALIZER_LAST_EN
    logic                 out_last;
    logic [15:0]          words_sent;

    modport master (
        input  in_first, in_first_rdy, in_deq_rdy, out_enq_rdy,
        output in_deq_ena, out_enq_v, out_enq_ena, busy, dbg_state, out_last, words_sent
    );
    modport slave (
        output in_first, in_first_rdy, in_deq_rdy, out_enq_rdy,
        input  in_deq_ena, out_enq_v, out_enq_ena, busy, dbg_state, out_last, words_sent
    );
`else
    modport master (
        input  in_first, in_first_rdy, in_deq_rdy, out_enq_rdy,
        output in_deq_ena, out_enq_v, out_enq_ena, busy, dbg_state
    );
    modport slave (
        output in_first, in_first_rdy, in_deq_rdy, out_enq_rdy,
        input  in_deq_ena, out_enq_v, out_enq_ena, busy, dbg_state
    );
`endif
endinterface

// File: rtl/pipe_serializer.sv
// pipe_serializer: dequeues one IN_WIDTH word and emits it as OUT_WIDTH beats, LS beat first,
// with zero-bubble reload on the last beat. Define SERIALIZER_LAST_EN for out_last/words_sent.
module pipe_serializer
    import echo_pkg::*;
#(
    parameter int IN_WIDTH  = ECHO_MSG_WIDTH,
    parameter int OUT_WIDTH = ECHO_BEAT_WIDTH
) (
    input  logic               CLK,
    input  logic               RST,
    pipe_serializer_if.master  bus
);

    localparam int BEATS = serializer_beats(IN_WIDTH, OUT_WIDTH);
    localparam int CW    = (BEATS < 1) ? 1 : $clog2(BEATS + 1);

    if (BEATS == 0) begin : g_width_check
        $error("pipe_serializer: IN_WIDTH must be a positive multiple of OUT_WIDTH");
    end

    ser_state_e          state, state_nx;
    logic [IN_WIDTH-1:0] sh, sh_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic                load_ok;
    logic                deq;
    logic                xfer;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sh    <= sh_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        cnt_nx   = cnt;
        deq      = 1'b0;
        xfer     = 1'b0;
        // Gated by RST so no dequeue strobe leaks out while the block is held in reset.
        load_ok  = bus.in_first_rdy & bus.in_deq_rdy & ~RST;
        case (state)
            IDLE: begin
                if (load_ok) begin
                    deq      = 1'b1;
                    sh_nx    = bus.in_first;
                    cnt_nx   = CW'(BEATS);
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (bus.out_enq_rdy) begin
                    xfer = 1'b1;
                    if (cnt == CW'(1)) begin
                        if (load_ok) begin
                            deq    = 1'b1;
                            sh_nx  = bus.in_first;
                            cnt_nx = CW'(BEATS);
                        end else begin
                            sh_nx    = sh >> OUT_WIDTH;
                            cnt_nx   = '0;
                            state_nx = IDLE;
                        end
                    end else begin
                        sh_nx  = sh >> OUT_WIDTH;
                        cnt_nx = cnt - CW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_deq_ena  = deq;
    assign bus.out_enq_ena = xfer;
    assign bus.out_enq_v   = sh[OUT_WIDTH-1:0];
    assign bus.busy        = (state == SEND);
    assign bus.dbg_state   = state;

`ifdef SERIALIZER_LAST_EN
    logic        last_xfer;
    logic [15:0] words_sent_q;

    assign last_xfer = xfer && (cnt == CW'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            words_sent_q <= '0;
        end else if (last_xfer) begin
            words_sent_q <= words_sent_q + 16'd1;
        end
    end

    assign bus.out_last   = (state == SEND) && (cnt == CW'(1));
    assign bus.words_sent = words_sent_q;
`endif

endmodule

// File: tb/tb_pipe_serializer.sv
// tb_pipe_serializer: directed bench for a 64/16 and a default 704/32 pipe_serializer; beat
// values go through per-instance expected queues, strobe timing is checked per cycle.
module tb_pipe_serializer;
    import echo_pkg::*;

    localparam int SW     = 64;
    localparam int SB     = 16;
    localparam int DW     = ECHO_MSG_WIDTH;
    localparam int DB     = ECHO_BEAT_WIDTH;
    localparam int DBEATS = DW / DB;

    localparam logic [SW-1:0] W1 = 64'h4444_3333_2222_1111;
    localparam logic [SW-1:0] W2 = 64'h8888_7777_6666_5555;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_serializer_if #(.IN_WIDTH(SW), .OUT_WIDTH(SB)) b16 ();
    pipe_serializer_if #(.IN_WIDTH(DW), .OUT_WIDTH(DB)) b32 ();

    pipe_serializer #(.IN_WIDTH(SW), .OUT_WIDTH(SB)) u_small (.CLK(clk), .RST(rst), .bus(b16));
    pipe_serializer #(.IN_WIDTH(DW), .OUT_WIDTH(DB)) u_dflt  (.CLK(clk), .RST(rst), .bus(b32));

    int checks = 0;
    int errors = 0;

    logic [SB-1:0] exp_q16[$];
    logic [DB-1:0] exp_q32[$];
    logic [SW-1:0] up16[$];
    logic [DW-1:0] up32[$];
    logic          deq_rdy16 = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (!rst && b16.out_enq_ena) begin
            check("b16_ena_needs_rdy", 64'(b16.out_enq_rdy), 64'd1);
            check("b16_beat_pending", 64'(exp_q16.size() != 0), 64'd1);
            if (exp_q16.size() != 0) check("b16_beat", 64'(b16.out_enq_v), 64'(exp_q16.pop_front()));
        end
        if (!rst && b32.out_enq_ena) begin
            check("b32_ena_needs_rdy", 64'(b32.out_enq_rdy), 64'd1);
            check("b32_beat_pending", 64'(exp_q32.size() != 0), 64'd1);
            if (exp_q32.size() != 0) check("b32_beat", 64'(b32.out_enq_v), 64'(exp_q32.pop_front()));
        end
        if (!rst && b16.in_deq_ena) check("b16_deq_needs_rdy", 64'(b16.in_deq_rdy & b16.in_first_rdy), 64'd1);
    end

    // ---------------- driver tasks ----------------
    task automatic drive_up();
        b16.in_deq_rdy   = deq_rdy16;
        b16.in_first_rdy = (up16.size() != 0);
        b16.in_first     = (up16.size() != 0) ? up16[0] : '0;
        b32.in_first_rdy = (up32.size() != 0);
        b32.in_first     = (up32.size() != 0) ? up32[0] : '0;
    endtask

    // Called at a negedge: retire dequeued heads, apply new inputs after the edge, return at
    // the following negedge so outputs can be sampled.
    task automatic next_cycle(input logic r16, input logic r32);
        logic d16;
        logic d32;
        d16 = b16.in_deq_ena;
        d32 = b32.in_deq_ena;
        @(posedge clk);
        #1;
        if (d16 && up16.size() != 0) void'(up16.pop_front());
        if (d32 && up32.size() != 0) void'(up32.pop_front());
        b16.out_enq_rdy = r16;
        b32.out_enq_rdy = r32;
        drive_up();
        @(negedge clk);
    endtask

    task automatic push16(input logic [SW-1:0] w);
        up16.push_back(w);
        for (int i = 0; i < SW / SB; i++) exp_q16.push_back(w[i*SB +: SB]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] wd;

        b16.in_first = '0; b16.in_first_rdy = 1'b0; b16.in_deq_rdy = 1'b1; b16.out_enq_rdy = 1'b1;
        b32.in_first = '0; b32.in_first_rdy = 1'b0; b32.in_deq_rdy = 1'b1; b32.out_enq_rdy = 1'b1;
        for (int i = 0; i < DBEATS; i++) wd[i*DB +: DB] = DB'(i + 1);

        repeat (2) @(negedge clk);
        check("rst_b16_busy", 64'(b16.busy), 64'd0);
        check("rst_b16_ena", 64'(b16.out_enq_ena), 64'd0);
        check("rst_b16_deq", 64'(b16.in_deq_ena), 64'd0);
        check("rst_b16_v", 64'(b16.out_enq_v), 64'd0);
        check("rst_b16_state", 64'(b16.dbg_state), 64'(IDLE));
        check("rst_b32_busy", 64'(b32.busy), 64'd0);
        check("rst_b32_v", 64'(b32.out_enq_v), 64'd0);
`ifdef SERIALIZER_LAST_EN
        check("rst_b16_last", 64'(b16.out_last), 64'd0);
        check("rst_b16_ws", 64'(b16.words_sent), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Upstream word present but in_deq_rdy low: no load.
        deq_rdy16 = 1'b0;
        push16(W1);
        next_cycle(1'b1, 1'b1);
        check("gate_deq", 64'(b16.in_deq_ena), 64'd0);
        next_cycle(1'b1, 1'b1);
        check("gate_busy", 64'(b16.busy), 64'd0);

        // Single word, downstream always ready.
        deq_rdy16 = 1'b1;
        next_cycle(1'b1, 1'b1);
        check("single_deq", 64'(b16.in_deq_ena), 64'd1);
        check("single_ena0", 64'(b16.out_enq_ena), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            next_cycle(1'b1, 1'b1);
            check("single_ena", 64'(b16.out_enq_ena), 64'd1);
            check("single_nodeq", 64'(b16.in_deq_ena), 64'd0);
            check("single_busy", 64'(b16.busy), 64'd1);
`ifdef SERIALIZER_LAST_EN
            check("single_last", 64'(b16.out_last), 64'(i == 4));
`endif
        end
        next_cycle(1'b1, 1'b1);
        check("single_idle", 64'(b16.busy), 64'd0);
        check("single_quiet", 64'(b16.out_enq_ena), 64'd0);

        // Back-to-back words: second dequeue on the fourth beat, no gap.
        push16(W1);
        push16(W2);
        next_cycle(1'b1, 1'b1);
        check("b2b_deq1", 64'(b16.in_deq_ena), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            next_cycle(1'b1, 1'b1);
            check("b2b_ena", 64'(b16.out_enq_ena), 64'd1);
            check("b2b_deq", 64'(b16.in_deq_ena), 64'(i == 4));
        end
        next_cycle(1'b1, 1'b1);
        check("b2b_idle", 64'(b16.busy), 64'd0);

        // Backpressure after beat 2, with the next word already waiting upstream.
        push16(W1);
        next_cycle(1'b1, 1'b1);
        check("bp_deq1", 64'(b16.in_deq_ena), 64'd1);
        next_cycle(1'b1, 1'b1);
        next_cycle(1'b1, 1'b1);
        check("bp_beat2_ena", 64'(b16.out_enq_ena), 64'd1);
        push16(W2);
        for (int i = 0; i < 3; i++) begin
            next_cycle(1'b0, 1'b1);
            check("bp_stall_ena", 64'(b16.out_enq_ena), 64'd0);
            check("bp_stall_v", 64'(b16.out_enq_v), 64'h3333);
            check("bp_stall_nodeq", 64'(b16.in_deq_ena), 64'd0);
            check("bp_stall_busy", 64'(b16.busy), 64'd1);
        end
        next_cycle(1'b1, 1'b1);
        check("bp_beat3_deq", 64'(b16.in_deq_ena), 64'd0);
        next_cycle(1'b1, 1'b1);
        check("bp_beat4_deq", 64'(b16.in_deq_ena), 64'd1);
        for (int i = 0; i < 4; i++) begin
            next_cycle(1'b1, 1'b1);
            check("bp_w2_ena", 64'(b16.out_enq_ena), 64'd1);
        end
        next_cycle(1'b1, 1'b1);
        check("bp_idle", 64'(b16.busy), 64'd0);
`ifdef SERIALIZER_LAST_EN
        check("b16_words_sent", 64'(b16.words_sent), 64'd5);
`endif

        // Default widths: 22 beats carrying 1..22.
        up32.push_back(wd);
        for (int i = 1; i <= DBEATS; i++) exp_q32.push_back(DB'(i));
        next_cycle(1'b1, 1'b1);
        check("dflt_deq", 64'(b32.in_deq_ena), 64'd1);
        for (int i = 1; i <= DBEATS; i++) begin
            next_cycle(1'b1, 1'b1);
            check("dflt_ena", 64'(b32.out_enq_ena), 64'd1);
`ifdef SERIALIZER_LAST_EN
            check("dflt_last", 64'(b32.out_last), 64'(i == DBEATS));
`endif
        end
        next_cycle(1'b1, 1'b1);
        check("dflt_idle", 64'(b32.busy), 64'd0);
        check("dflt_quiet", 64'(b32.out_enq_ena), 64'd0);
`ifdef SERIALIZER_LAST_EN
        check("dflt_words_sent", 64'(b32.words_sent), 64'd1);
`endif

        // Reset mid-word: 18th beat is on the bus with cnt=5 when RST rises.
        up32.push_back(wd);
        for (int i = 1; i <= 18; i++) exp_q32.push_back(DB'(i));
        next_cycle(1'b1, 1'b1);
        check("mid_deq", 64'(b32.in_deq_ena), 64'd1);
        for (int i = 1; i <= 18; i++) begin
            next_cycle(1'b1, 1'b1);
            check("mid_ena", 64'(b32.out_enq_ena), 64'd1);
        end
        #2 rst = 1'b1;
        #1;
        check("mid_async_busy", 64'(b32.busy), 64'd0);
        check("mid_async_ena", 64'(b32.out_enq_ena), 64'd0);
        check("mid_async_v", 64'(b32.out_enq_v), 64'd0);
        check("mid_async_state", 64'(b32.dbg_state), 64'(IDLE));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            next_cycle(1'b1, 1'b1);
            check("mid_after_ena", 64'(b32.out_enq_ena), 64'd0);
            check("mid_after_busy", 64'(b32.busy), 64'd0);
        end
`ifdef SERIALIZER_LAST_EN
        check("mid_words_sent", 64'(b32.words_sent), 64'd0);
`endif

        check("b16_sb_drained", 64'(exp_q16.size()), 64'd0);
        check("b32_sb_drained", 64'(exp_q32.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
